// File: rtl/stream_input_loader.sv
// Stream loader: 5 config beats, then 32-bit instruction words and data words as 16-bit half pairs.
// Latency: a memory write is presented one cycle after its second half is accepted.
// Backpressure: in_rdy drops while a write waits for mem_gnt and in DONE. Optional LOADER_CHECKSUM_EN adds a checksum output.
module stream_input_loader #(
  parameter int IO_WIDTH     = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int CONFIG_WIDTH = 16,
  parameter int NUM_CONFIGS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IO_WIDTH-1:0]   in_data,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic                  reload,
  output logic                  instr_wen,
  output logic [ADDR_WIDTH-1:0] instr_wadr,
  output logic                  data_wen,
  output logic [ADDR_WIDTH-1:0] wadr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] instr_max_wadr,
  output logic [ADDR_WIDTH-1:0] input_max_wadr,
  output logic [ADDR_WIDTH-1:0] input_wadr_offset,
  output logic [ADDR_WIDTH-1:0] output_max_adr,
  output logic [ADDR_WIDTH-1:0] output_adr_offset,
  output logic                  load_done,
  output logic                  busy
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {S_CFG, S_INSTR, S_DATA, S_DONE} state_t;

  localparam int CNT_W = (NUM_CONFIGS > 1) ? $clog2(NUM_CONFIGS) : 1;
  localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(NUM_CONFIGS - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   cfg_q [NUM_CONFIGS];
  logic [CNT_W-1:0]        beat_cnt;
  logic                    half_q;
  logic [IO_WIDTH-1:0]     lo_half;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [CONFIG_WIDTH-1:0] cfg_beat;
  logic                    pending;
  logic                    accept;
  logic                    phase_last;

  assign pending  = instr_wen | data_wen;
  assign in_rdy   = (state_q != S_DONE) && !(pending && !mem_gnt);
  assign accept   = in_vld && in_rdy;
  assign cfg_beat = CONFIG_WIDTH'(in_data);

  // Last word of the current memory phase, compared against its configured max index.
  assign phase_last = (state_q == S_INSTR) ? (word_idx == cfg_q[0]) : (word_idx == cfg_q[1]);

  assign instr_max_wadr    = cfg_q[0];
  assign input_max_wadr    = cfg_q[1];
  assign input_wadr_offset = cfg_q[2];
  assign output_max_adr    = cfg_q[3];
  assign output_adr_offset = cfg_q[4];

  assign load_done = (state_q == S_DONE);
  assign busy      = (state_q != S_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_CFG;
    else     state_q <= state_d;
  end

  // Next state: reload wins over any beat; phases advance on the accepting beat itself.
  always_comb begin
    state_d = state_q;
    if (reload) begin
      state_d = S_CFG;
    end else begin
      case (state_q)
        S_CFG:   if (accept && beat_cnt == CFG_LAST) state_d = S_INSTR;
        S_INSTR: if (accept && half_q && phase_last) state_d = S_DATA;
        S_DATA:  if (accept && half_q && phase_last) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Config capture, half packing, word indexing and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CONFIGS; k++) cfg_q[k] <= '0;
      beat_cnt   <= '0;
      half_q     <= 1'b0;
      lo_half    <= '0;
      word_idx   <= '0;
      instr_wen  <= 1'b0;
      data_wen   <= 1'b0;
      instr_wadr <= '0;
      wadr       <= '0;
      mem_wdata  <= '0;
    end else if (reload) begin
      // Discard the partial load; config registers keep their old values until rewritten.
      beat_cnt  <= '0;
      half_q    <= 1'b0;
      word_idx  <= '0;
      instr_wen <= 1'b0;
      data_wen  <= 1'b0;
    end else begin
      if (pending && mem_gnt) begin
        instr_wen <= 1'b0;
        data_wen  <= 1'b0;
      end
      if (accept) begin
        case (state_q)
          S_CFG: begin
            for (int k = 0; k < NUM_CONFIGS; k++)
              if (beat_cnt == CNT_W'(k)) cfg_q[k] <= ADDR_WIDTH'(cfg_beat);
            beat_cnt <= (beat_cnt == CFG_LAST) ? '0 : beat_cnt + CNT_W'(1);
          end
          S_INSTR, S_DATA: begin
            if (!half_q) begin
              lo_half <= in_data;
              half_q  <= 1'b1;
            end else begin
              half_q    <= 1'b0;
              mem_wdata <= {in_data, lo_half};
              if (state_q == S_INSTR) begin
                instr_wen  <= 1'b1;
                instr_wadr <= word_idx;
              end else begin
                data_wen <= 1'b1;
                wadr     <= cfg_q[2] + word_idx;
              end
              word_idx <= phase_last ? '0 : word_idx + ADDR_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of every completed memory write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     checksum <= '0;
    else if (reload)             checksum <= '0;
    else if (pending && mem_gnt) checksum <= checksum + mem_wdata;
  end
`endif

endmodule

// File: doc/stream_input_loader.md
Name: stream_input_loader

Overview:
- Front-end loader inside user_proj_example, directly downstream of the 16-bit io_in stream pins.
- Consumes the host stream in three phases:
  - 5 config words, which set the memory bounds and offsets.
  - Instruction words, 32-bit, sent as two 16-bit halves.
  - Input data words, 32-bit, sent as two 16-bit halves.
- Drives the instruction-memory and data-memory write ports, and publishes the config registers to the accelerator and the output serializer.

Parameters:
- IO_WIDTH, 16, stream beat width.
- DATA_WIDTH, 32, memory word width; must equal 2*IO_WIDTH.
- ADDR_WIDTH, 16, memory address width.
- CONFIG_WIDTH, 16, config register width.
- NUM_CONFIGS, 5, config beats per load.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- in_data  in  IO_WIDTH  stream beat
- in_vld  in  1  beat valid
- in_rdy  out  1  loader can accept a beat
- reload  in  1  single-cycle pulse; restarts the load sequence from the config phase
- instr_wen  out  1  instruction memory write enable
- instr_wadr  out  ADDR_WIDTH  instruction write address
- data_wen  out  1  data memory write enable
- wadr  out  ADDR_WIDTH  data write address
- mem_wdata  out  DATA_WIDTH  write data, shared by both memories
- mem_gnt  in  1  memory port grant; a write completes on a cycle with wen && mem_gnt
- instr_max_wadr  out  ADDR_WIDTH  config[0]
- input_max_wadr  out  ADDR_WIDTH  config[1]
- input_wadr_offset  out  ADDR_WIDTH  config[2]
- output_max_adr  out  ADDR_WIDTH  config[3]
- output_adr_offset  out  ADDR_WIDTH  config[4]
- load_done  out  1  high in DONE
- busy  out  1  high in CFG, INSTR or DATA

Behaviour:
- Beat accepted on a cycle with in_vld && in_rdy.
- Reset values:
  - state = CFG.
  - All config registers = 0.
  - Beat counter, half flag and word index = 0.
  - instr_wen = 0, data_wen = 0.
  - Addresses and mem_wdata = 0.
  - load_done = 0, busy = 1.
- Reset is asynchronous and may assert mid-load. The partial load is discarded and any pending write is dropped.
- in_rdy = (state != DONE) && !(write pending && !mem_gnt). A write is pending while instr_wen or data_wen is high.
- CFG state:
  - Beat k (k = 0..NUM_CONFIGS-1) loads config[k], zero-extended to ADDR_WIDTH.
  - After beat NUM_CONFIGS-1, go to INSTR.
- INSTR state:
  - First beat of a pair = mem_wdata[15:0]; second beat = mem_wdata[31:16].
  - On the second beat: instr_wen goes high on the next cycle, with instr_wadr = word index.
  - After word index instr_max_wadr is written, go to DATA and clear the word index.
- DATA state:
  - Same half packing as INSTR.
  - wadr = input_wadr_offset + word index, modulo 2^ADDR_WIDTH (wrap-around permitted).
  - After word index input_max_wadr is written, go to DONE.
- DONE state:
  - in_rdy = 0, load_done = 1, busy = 0.
  - Config registers hold their values.
  - Stay in DONE until reload.
- Write latency: the wen pulse is registered one cycle after the accepting edge of the second beat.
  - wen, address and data hold until mem_gnt = 1, then clear on the next edge.
  - A first-half beat may be accepted while a write is pending only if mem_gnt = 1 that cycle.
- Phase transition: the INSTR→DATA transition occurs on the acceptance of the last instruction beat, so the next beat is already treated as data.
- A max value of 0 means one word in that phase.
- reload:
  - In DONE: go to CFG.
  - In any other state: also restarts at CFG, clears the counters and drops any pending write.
  - reload takes priority over a beat accepted in the same cycle; that beat is discarded.
- Odd beat count: if the final phase ends on an unpaired half, the half is held until the next beat. No timeout.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[DATA_WIDTH-1:0], the modulo-2^32 sum of every word written to either memory.
  - A word is summed on the cycle its write completes (wen && mem_gnt).
  - Cleared by rst and by reload.
- When undefined: the port and adder are absent, and behaviour is otherwise identical.

Test Plan:
- Basic load:
  - Stimulus: config {3,1,0x07D0,1,0x07E8}, then 4 instruction words 0x11112222..0x44448888, then 2 data words 0xDEADBEEF and 0x01234567; mem_gnt tied high.
  - Response: instr writes at addresses 0..3 with correct packing; data writes at 0x07D0 and 0x07D1; load_done = 1 and in_rdy = 0 after the last beat.
- Backpressure:
  - Stimulus: mem_gnt held low for 5 cycles on the 2nd instruction word.
  - Response: instr_wen, instr_wadr = 1 and data stay stable; in_rdy = 0 throughout; write completes on the first gnt cycle; no beat lost.
- Address wrap:
  - Stimulus: input_wadr_offset = 0xFFFF, input_max_wadr = 2.
  - Response: data writes at 0xFFFF, 0x0000, 0x0001.
- Mid-load interruption:
  - Stimulus: rst, then separately reload, asserted after 3 instruction beats.
  - Response: no write issued for the half word; state = CFG; the next 5 beats rewrite the config registers.
- Bubbles:
  - Stimulus: in_vld toggling every other cycle; instr_max_wadr = 0.
  - Response: exactly one instruction write at address 0; the transition to DATA is correct.
- LOADER_CHECKSUM_EN:
  - Stimulus: basic load scenario with the macro defined.
  - Response: checksum = 0x11112222 + 0x22224444 + 0x33336666 + 0x44448888 + 0xDEADBEEF + 0x01234567 (mod 2^32).
